// File: rtl/m_unit_pkg.sv
// ============================================================================
// m_unit_pkg : shared encodings and constants for the RV32M iterative unit
// Rev 1.0
// ============================================================================
`default_nettype none

package m_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [5:0]  ITER_LAST = 6'd31;

endpackage

`default_nettype wire

// File: rtl/m_unit_iter_core.sv
// ============================================================================
// m_unit_iter_core : 2*XLEN-bit shift register with adder/subtractor doing one
//                    shift-add multiply or restoring-divide step per cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module m_unit_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [2*XLEN-1:0] load_acc,
  input  logic [XLEN-1:0]   load_opd,
  input  logic              step,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opd;
  logic [XLEN:0]     w_add;
  logic [XLEN:0]     w_sub;
  logic [2*XLEN-1:0] w_mul_step;
  logic [2*XLEN-1:0] w_div_step;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in
  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opd};
  assign w_mul_step = r_acc[0] ? {w_add, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};

  // Divide: partial remainder is upper half after shift; 33-bit compare covers its carry-out
  assign w_sub      = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opd};
  assign w_div_step = w_sub[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                  : {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign acc_next = is_div ? w_div_step : w_mul_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_opd <= '0;
    end else if (load) begin
      r_acc <= load_acc;
      r_opd <= load_opd;
    end else if (step) begin
      r_acc <= acc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/m_unit.sv
// ============================================================================
// m_unit : iterative RV32M multiply/divide unit (FSM, signs, special cases).
//          M_UNIT_FAST_MUL_EN selects a single-cycle array multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

module m_unit
  import m_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            func3,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       op2,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  flush,
  output logic                  busy,
  output logic                  ready,
  output logic [XLEN-1:0]       result,
  output logic                  wr,
  output logic [REG_ADDR_W-1:0] dest_out
);

  state_t                r_state, w_state_next;
  logic [5:0]            r_cnt, w_cnt_next;
  logic [2:0]            r_func3;
  logic                  r_s1, r_s2;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [XLEN-1:0]       r_result;
  logic                  r_wr;
  logic [REG_ADDR_W-1:0] r_dest_out;

  logic                  w_sgn1, w_sgn2, w_s1, w_s2;
  logic [XLEN-1:0]       w_mag1, w_mag2;
  logic                  w_is_div, w_special;
  logic [XLEN-1:0]       w_special_val;
  logic                  w_load, w_step, w_out_load;
  logic [XLEN-1:0]       w_out_val;
  logic [REG_ADDR_W-1:0] w_out_dest;
  logic [2*XLEN-1:0]     w_acc_next, w_prod;
  logic [XLEN-1:0]       w_quot, w_rem, w_final;

  assign w_sgn1   = (func3 != F3_MULHU) && (func3 != F3_DIVU) && (func3 != F3_REMU);
  assign w_sgn2   = w_sgn1 && (func3 != F3_MULHSU);
  assign w_s1     = w_sgn1 & op1[XLEN-1];
  assign w_s2     = w_sgn2 & op2[XLEN-1];
  assign w_mag1   = w_s1 ? -op1 : op1;
  assign w_mag2   = w_s2 ? -op2 : op2;
  assign w_is_div = func3[2];

  assign w_special = w_is_div && ((op2 == '0) ||
                     (!func3[0] && (op1 == INT_MIN) && (op2 == '1)));
  // func3[1] separates REM* from DIV*
  assign w_special_val = (op2 == '0) ? (func3[1] ? op1 : DIV0_QUOT)
                                     : (func3[1] ? '0  : INT_MIN);

  m_unit_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_acc ({{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)}),
    .load_opd (w_is_div ? w_mag2 : w_mag1),
    .step     (w_step),
    .is_div   (r_func3[2]),
    .acc_next (w_acc_next)
  );

  // Signs applied on the last step's output so the result register loads on entry to DONE
  assign w_prod = (r_s1 ^ r_s2) ? -w_acc_next : w_acc_next;
  assign w_quot = (r_s1 ^ r_s2) ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = r_s1 ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_rem;
    case (r_func3)
      F3_MUL:                      w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             w_final = w_quot;
      default:                     w_final = w_rem;
    endcase
  end

`ifdef M_UNIT_FAST_MUL_EN
  logic [XLEN-1:0]          r_op1, r_op2;
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN+1:0] w_fp;
  logic [XLEN-1:0]          w_fast_res;

  assign w_fa       = {r_s1, r_op1};
  assign w_fb       = {r_s2, r_op2};
  assign w_fp       = (2*XLEN+2)'(w_fa) * (2*XLEN+2)'(w_fb);
  assign w_fast_res = (r_func3 == F3_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (w_load) begin
      r_op1 <= op1;
      r_op2 <= op2;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_out_load   = 1'b0;
    w_out_val    = w_final;
    w_out_dest   = r_dest;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          w_load     = 1'b1;
          w_cnt_next = '0;
          if (w_special) begin
            w_state_next = DONE;
            w_out_load   = 1'b1;
            w_out_val    = w_special_val;
            w_out_dest   = dest;
          end else begin
            w_state_next = w_is_div ? DIV_ITER : MUL_ITER;
          end
        end
      end
      MUL_ITER: begin
`ifdef M_UNIT_FAST_MUL_EN
        w_state_next = DONE;
        w_out_load   = 1'b1;
        w_out_val    = w_fast_res;
`else
        w_step = 1'b1;
        if (r_cnt == ITER_LAST) begin
          w_state_next = DONE;
          w_out_load   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 6'd1;
        end
`endif
      end
      DIV_ITER: begin
        w_step = 1'b1;
        if (r_cnt == ITER_LAST) begin
          w_state_next = DONE;
          w_out_load   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 6'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) begin
      w_state_next = IDLE;
      w_load       = 1'b0;
      w_out_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_func3    <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_dest     <= '0;
      r_result   <= '0;
      r_wr       <= 1'b0;
      r_dest_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_func3 <= func3;
        r_s1    <= w_s1;
        r_s2    <= w_s2;
        r_dest  <= dest;
      end
      if (w_out_load) begin
        r_result   <= w_out_val;
        r_wr       <= (w_out_dest != '0);
        r_dest_out <= w_out_dest;
      end
    end
  end

  assign busy     = (start && (r_state == IDLE)) || (r_state == MUL_ITER) || (r_state == DIV_ITER);
  assign ready    = (r_state == DONE) && !flush;
  assign result   = r_result;
  assign wr       = r_wr;
  assign dest_out = r_dest_out;

endmodule

`default_nettype wire

// File: tb/tb_m_unit.sv
// ============================================================================
// tb_m_unit : directed self-checking bench for m_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_m_unit;
  import m_unit_pkg::*;

`ifdef M_UNIT_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk, rst_n, start, flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  dest;
  logic        busy, ready, wr;
  logic [31:0] result;
  logic [4:0]  dest_out;

  int n_total = 0;
  int n_bad   = 0;

  m_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .func3    (func3),
    .op1      (op1),
    .op2      (op2),
    .dest     (dest),
    .flush    (flush),
    .busy     (busy),
    .ready    (ready),
    .result   (result),
    .wr       (wr),
    .dest_out (dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // exp_lat==0 means no ready may appear; flush_at/inject_at are cycle offsets from T (-1 = none)
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input int exp_lat,
                        input int exp_busy, input logic [31:0] exp_res, input logic exp_wr,
                        input int flush_at, input int inject_at);
    int lat, nbusy;
    logic [31:0] got_res;
    logic got_wr;
    logic [4:0] got_dest;
    lat = 0; nbusy = 0; got_res = '0; got_wr = 1'b0; got_dest = '0;
    @(negedge clk);
    start = 1'b1; func3 = f; op1 = a; op2 = b; dest = d; flush = (flush_at == 0);
    #1 check({tag, "_busyT"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == inject_at) && (lat == 0);
      if (start) begin
        func3 = F3_MUL; op1 = 32'h55; op2 = 32'h66; dest = 5'd9;
      end
      flush = (k == flush_at);
      #1;
      if (lat != 0) begin
        check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        check({tag, "_hold"}, result, exp_res);
        break;
      end
      if (busy) nbusy++;
      if (ready) begin
        lat = k; got_res = result; got_wr = wr; got_dest = dest_out;
      end
    end
    start = 1'b0; flush = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busycnt"}, nbusy, exp_busy);
    if (exp_lat != 0) begin
      check({tag, "_res"}, got_res, exp_res);
      check({tag, "_wr"}, {31'd0, got_wr}, {31'd0, exp_wr});
      check({tag, "_dest"}, {27'd0, got_dest}, {27'd0, d});
    end
  endtask

  initial begin
    int nready;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0; dest = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_res",   result,         32'd0);
    check("rst_wr",    {31'd0, wr},    32'd0);
    check("rst_dest",  {27'd0, dest_out}, 32'd0);
    rst_n = 1'b1;

    run_op("mul",    F3_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, MUL_LAT, MUL_LAT-1, 32'hFFFF_FFEB, 1'b1, -1, -1);
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, MUL_LAT, MUL_LAT-1, 32'h4000_0000, 1'b1, -1, -1);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, MUL_LAT, MUL_LAT-1, 32'hFFFF_FFFE, 1'b1, -1, -1);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8, MUL_LAT, MUL_LAT-1, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,   5'd10, DIV_LAT, DIV_LAT-1, 32'hFFFF_FFFD, 1'b1, -1, -1);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,   5'd11, DIV_LAT, DIV_LAT-1, 32'hFFFF_FFFF, 1'b1, -1, -1);
    // stray start mid-operation must not disturb the running divide
    run_op("divu",   F3_DIVU,   32'd100, 32'd7,         5'd12, DIV_LAT, DIV_LAT-1, 32'd14, 1'b1, -1, 3);
    run_op("remu",   F3_REMU,   32'd100, 32'd7,         5'd13, DIV_LAT, DIV_LAT-1, 32'd2,  1'b1, -1, -1);
    run_op("div0",   F3_DIV,    32'd5,   32'd0,         5'd14, 1, 0, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op("rem0",   F3_REM,    32'd5,   32'd0,         5'd15, 1, 0, 32'd5,         1'b1, -1, -1);
    run_op("divovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 0, 32'h8000_0000, 1'b1, -1, -1);
    run_op("removf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 0, 32'd0,         1'b1, -1, -1);
    run_op("mulx0",  F3_MUL,    32'd3,   32'd4,         5'd0,  MUL_LAT, MUL_LAT-1, 32'd12, 1'b0, -1, -1);
    run_op("dflush", F3_DIV,    32'd1000, 32'd3,        5'd18, 0, 10, 32'd0, 1'b0, 10, -1);
    run_op("after",  F3_DIVU,   32'd1000, 32'd3,        5'd19, DIV_LAT, DIV_LAT-1, 32'd333, 1'b1, -1, -1);
    run_op("stfl",   F3_MUL,    32'd9,   32'd9,         5'd20, 0, 0, 32'd0, 1'b0, 0, -1);
    run_op("doneflush", F3_MUL, 32'd2,   32'd3,         5'd21, 0, MUL_LAT-1, 32'd0, 1'b0, MUL_LAT, -1);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; func3 = F3_DIVU; op1 = 32'd77; op2 = 32'd5; dest = 5'd22;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'd0, busy},  32'd0);
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_res",   result,         32'd0);
    check("arst_wr",    {31'd0, wr},    32'd0);
    check("arst_dest",  {27'd0, dest_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nready = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("arst_noready", nready, 32'd0);
    run_op("post", F3_MUL, 32'd6, 32'd7, 5'd23, MUL_LAT, MUL_LAT-1, 32'd42, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/m_unit.md
Name: m_unit

Overview:
Iterative RV32M multiply/divide unit feeding the execute stage's M-unit result path.
- Accepts forwarded operands plus func3 from EX.
- Asserts `busy` so hazard logic stalls the pipeline.
- Returns the result, destination and write-enable with a one-cycle `ready` pulse; EX muxes these onto its writeback path.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  valid M-extension instruction in EX this cycle (opcode R-type, func7=0000001).
- func3  in  3  M operation select.
- op1  in  32  forwarded rs1.
- op2  in  32  forwarded rs2.
- dest  in  5  rd of the instruction.
- flush  in  1  pipeline flush; kills the in-flight operation.
- busy  out  1  stall request.
- ready  out  1  result valid, single-cycle pulse.
- result  out  32  operation result.
- wr  out  1  register-file write enable, valid with ready.
- dest_out  out  5  rd, valid with ready.

Behaviour:
- func3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Reset: state IDLE; busy=0, ready=0, wr=0, result=0, dest_out=0; all datapath registers 0.
- States and transitions:
  - IDLE: start && !flush latches operands, func3, dest and iteration count=0.
    - Special-case division → DONE.
    - MUL* → MUL_ITER.
    - DIV*/REM* → DIV_ITER.
  - MUL_ITER: radix-2 shift-add on 32-bit magnitudes into a 64-bit accumulator; 32 cycles, then DONE.
  - DIV_ITER: restoring division on magnitudes, one quotient bit per cycle; 32 cycles, then DONE.
  - DONE: ready=1 for exactly one cycle, then IDLE.
- Latency (start in cycle T):
  - Iterative op: ready in T+33.
  - Special case: ready in T+1.
- busy = (start && state==IDLE) || state in {MUL_ITER, DIV_ITER}. It is combinational from start so EX stalls in cycle T. busy=0 during DONE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Operands are converted to magnitudes on entry; the sign is applied in the cycle before DONE.
  - Product sign = s1^s2.
  - Quotient sign = s1^s2.
  - Remainder sign = s1.
- Result select:
  - MUL → product[31:0].
  - MULH/MULHSU/MULHU → product[63:32].
  - DIV/DIVU → quotient.
  - REM/REMU → remainder.
- Special cases (no iteration):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- wr = 0 when dest==0; ready still pulses.
- result, dest_out and wr are registered and hold their value after ready drops until the next DONE.
- Boundary conditions:
  - start while not IDLE is ignored; EX is stalled, so this is a protocol violation and must not corrupt state.
  - flush in any state → IDLE next cycle. In DONE, flush forces ready=0 that cycle. The held result is unchanged.
  - start and flush in the same cycle: start is ignored.
  - rst_n low mid-operation clears everything asynchronously; no ready is produced.
  - Iteration counter is 6 bits; terminal count 31 triggers DONE with no wrap.

Optional Feature:
- Macro: M_UNIT_FAST_MUL_EN.
- Defined: MUL_ITER lasts one cycle using a 33x33 signed array multiply (operands sign/zero-extended per func3), so ready arrives in T+2 for all MUL*. Division is unchanged.
- Undefined: 32-cycle shift-add as above; no `*` operator is synthesised.

Decomposition:
- Shared package m_unit_pkg:
  - func3 localparams (F3_MUL … F3_REMU).
  - State encoding (IDLE, MUL_ITER, DIV_ITER, DONE).
  - DIV0_QUOT = 0xFFFFFFFF, INT_MIN = 0x80000000.
  - ITER_LAST = 31.
- Sub-module m_unit_iter_core: the shared 64-bit shift register / adder-subtractor performing one mul or div step per cycle.
- m_unit keeps the FSM, sign handling, special cases and output registers.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD, dest=5 → busy T..T+32, ready at T+33, result=0xFFFFFFEB, wr=1, dest_out=5.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both ready at T+1. DIV 0x80000000/−1 → 0x80000000, REM → 0, ready at T+1.
- DIV started, flush at T+10 → busy=0 at T+11, no ready ever; a new start at T+12 completes normally. rst_n low mid-operation → all outputs 0.
- MUL with dest=0 → ready pulse with wr=0. With M_UNIT_FAST_MUL_EN defined, MUL 7×−3 → ready at T+2.
